// File: rtl/addition_stage32_if.sv
// rtl/addition_stage32_if.sv - operand/result bundle for addition_stage32
// Ports: en, loadN, loadA, PlusOrMinus, A, B, cin (master -> slave);
//        sumFinal, cout, ready (slave -> master).
interface addition_stage32_if;
  logic        en;
  logic        loadN;
  logic        loadA;
  logic        PlusOrMinus;
  logic [31:0] A;
  logic [31:0] B;
  logic        cin;
  logic [31:0] sumFinal;
  logic        cout;
  logic        ready;

  modport master (
    output en, loadN, loadA, PlusOrMinus, A, B, cin,
    input  sumFinal, cout, ready
  );

  modport slave (
    input  en, loadN, loadA, PlusOrMinus, A, B, cin,
    output sumFinal, cout, ready
  );
endinterface

// File: rtl/addition_stage32.sv
// rtl/addition_stage32.sv - sequential FP add/subtract stage (align, add, normalise)
// Ports: clk, rst (sync, active-high); bus (addition_stage32_if.slave):
//   en clock enable, loadN operand capture, loadA adder-input stall,
//   PlusOrMinus 0=A+B 1=A-B, A/B {sign, signed exp[7:0], frac[22:0]}, cin,
//   sumFinal IEEE-754 result, cout significand carry, ready result valid.
// Build option: ROUND_NEAREST_EN enables guard/round/sticky and round-to-nearest-even.
module addition_stage32 #(
  parameter int EXP_BIAS = 127
) (
  input logic               clk,
  input logic               rst,
  addition_stage32_if.slave bus
);

`ifdef ROUND_NEAREST_EN
  localparam int GRS = 3;
`else
  localparam int GRS = 0;
`endif
  // Working significand: hidden 1 at bit SW-1, GRS extra low-order bits.
  localparam int SW = 24 + GRS;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ALIGN, S_ADD, S_NORM, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic                pm_q, pm_d;
  logic                cin_q, cin_d;
  logic [SW-1:0]       sig_a_q, sig_a_d;
  logic [SW-1:0]       sig_b_q, sig_b_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic signed [10:0]  exp_q, exp_d;
  logic [SW:0]         sum_q, sum_d;
  logic                sum_sign_q, sum_sign_d;
  logic                cout_q, cout_d;
  logic [31:0]         sum_final_q, sum_final_d;
  logic                ready_q, ready_d;

  // Right shift; in rounding builds lost bits collapse into the sticky LSB.
  function automatic logic [SW-1:0] shr(input logic [SW-1:0] v, input logic [8:0] s);
    logic [SW-1:0] r;
    r = v >> s;
`ifdef ROUND_NEAREST_EN
    r[0] = r[0] | (|(v & ~({SW{1'b1}} << s)));
`endif
    return r;
  endfunction

  // ---------------- align datapath (from latched operands) ----------------
  logic signed [7:0] ea, eb;
  logic signed [8:0] diff;
  logic              a_big;
  logic [8:0]        sh, sh_c;
  logic [SW-1:0]     ext_a, ext_b, al_a, al_b;
  logic signed [10:0] al_exp;

  always_comb begin
    ea    = a_q[30:23];
    eb    = b_q[30:23];
    // bits[30:0] all zero encodes the value zero: no hidden 1.
    ext_a = (a_q[30:0] == 31'd0) ? '0 : SW'({1'b1, a_q[22:0]}) << GRS;
    ext_b = (b_q[30:0] == 31'd0) ? '0 : SW'({1'b1, b_q[22:0]}) << GRS;
    diff  = {ea[7], ea} - {eb[7], eb};
    a_big = (diff >= 0);
    sh    = a_big ? unsigned'(diff) : unsigned'(-diff);
    sh_c  = (sh > 9'(SW)) ? 9'(SW) : sh;
    al_a  = a_big ? ext_a : shr(ext_a, sh_c);
    al_b  = a_big ? shr(ext_b, sh_c) : ext_b;
    al_exp = a_big ? {{3{ea[7]}}, ea} : {{3{eb[7]}}, eb};
  end

  // ---------------- add datapath ----------------
  logic [SW:0] add_sum, sub_diff, cin_ext;
  logic        a_ge;

  always_comb begin
    cin_ext  = (SW+1)'(cin_q) << GRS;
    add_sum  = {1'b0, sig_a_q} + {1'b0, sig_b_q} + cin_ext;
    a_ge     = (sig_a_q >= sig_b_q);
    sub_diff = a_ge ? ({1'b0, sig_a_q} - {1'b0, sig_b_q})
                    : ({1'b0, sig_b_q} - {1'b0, sig_a_q});
  end

  // ---------------- normalise datapath ----------------
  logic [4:0]         lz;
  logic [SW-1:0]      norm_m;
  logic signed [10:0] norm_e, biased;
  logic [23:0]        mant;
  logic [31:0]        result;
`ifdef ROUND_NEAREST_EN
  logic               rnd_up;
  logic [24:0]        rnd;
`endif

  always_comb begin
    // Priority from LSB upward leaves lz set by the most significant 1.
    lz = '0;
    for (int i = 0; i < SW; i++) begin
      if (sum_q[i]) lz = 5'(SW - 1 - i);
    end
    if (sum_q[SW]) begin
      norm_m = sum_q[SW:1];
`ifdef ROUND_NEAREST_EN
      norm_m[0] = norm_m[0] | sum_q[0];
`endif
      norm_e = exp_q + 11'sd1;
    end else begin
      norm_m = sum_q[SW-1:0] << lz;
      norm_e = exp_q - signed'({6'd0, lz});
    end
`ifdef ROUND_NEAREST_EN
    // Nearest-even; a carry out of the rounded significand renormalises here.
    rnd_up = norm_m[2] & ((|norm_m[1:0]) | norm_m[3]);
    rnd    = {1'b0, norm_m[SW-1:3]} + 25'(rnd_up);
    if (rnd[24]) begin
      mant   = rnd[24:1];
      norm_e = norm_e + 11'sd1;
    end else begin
      mant   = rnd[23:0];
    end
`else
    mant = norm_m;
`endif
    biased = norm_e + signed'(11'(EXP_BIAS));
    if (sum_q == '0 || biased <= 0) begin
      result = 32'd0;
    end else if (biased >= 11'sd255) begin
      result = {sum_sign_q, 8'hFF, 23'd0};
    end else begin
      result = {sum_sign_q, biased[7:0], mant[22:0]};
    end
  end

  // ---------------- control ----------------
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    pm_d        = pm_q;
    cin_d       = cin_q;
    sig_a_d     = sig_a_q;
    sig_b_d     = sig_b_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    exp_d       = exp_q;
    sum_d       = sum_q;
    sum_sign_d  = sum_sign_q;
    cout_d      = cout_q;
    sum_final_d = sum_final_q;
    ready_d     = ready_q;

    if (bus.loadN) begin
      a_d     = bus.A;
      b_d     = bus.B;
      pm_d    = bus.PlusOrMinus;
      cin_d   = bus.cin;
      ready_d = 1'b0;
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_LOAD: state_d = S_ALIGN;
        S_ALIGN, S_ADD: begin
          if (state_q == S_ALIGN || bus.loadA) begin
            sig_a_d  = al_a;
            sig_b_d  = al_b;
            sign_a_d = a_q[31];
            sign_b_d = b_q[31] ^ pm_q;
            exp_d    = al_exp;
            ready_d  = 1'b0;
            state_d  = S_ADD;
          end else begin
            if (sign_a_q == sign_b_q) begin
              sum_d      = add_sum;
              sum_sign_d = sign_a_q;
              cout_d     = add_sum[SW];
            end else begin
              sum_d      = sub_diff;
              sum_sign_d = a_ge ? sign_a_q : sign_b_q;
              cout_d     = 1'b0;
            end
            state_d = S_NORM;
          end
        end
        S_NORM: begin
          sum_final_d = result;
          ready_d     = 1'b1;
          state_d     = S_DONE;
        end
        S_DONE: begin
          if (bus.loadA) begin
            ready_d = 1'b0;
            state_d = S_ADD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      pm_q        <= 1'b0;
      cin_q       <= 1'b0;
      sig_a_q     <= '0;
      sig_b_q     <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      exp_q       <= '0;
      sum_q       <= '0;
      sum_sign_q  <= 1'b0;
      cout_q      <= 1'b0;
      sum_final_q <= '0;
      ready_q     <= 1'b0;
    end else if (bus.en) begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pm_q        <= pm_d;
      cin_q       <= cin_d;
      sig_a_q     <= sig_a_d;
      sig_b_q     <= sig_b_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      exp_q       <= exp_d;
      sum_q       <= sum_d;
      sum_sign_q  <= sum_sign_d;
      cout_q      <= cout_d;
      sum_final_q <= sum_final_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.sumFinal = sum_final_q;
  assign bus.cout     = cout_q;
  assign bus.ready    = ready_q;

endmodule

// File: tb/tb_addition_stage32.sv
// tb/tb_addition_stage32.sv - directed vector bench for addition_stage32
module tb_addition_stage32;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addition_stage32_if bus();
  addition_stage32 #(.EXP_BIAS(127)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        pm;
    logic        ci;
    int          stall;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Pulse loadN with operands, leave loadN low; returns at the negedge before
  // the edge that sees loadN=0 in LOAD.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic pm, input logic ci);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.PlusOrMinus = pm; bus.cin = ci;
    bus.loadN = 1'b1; bus.loadA = 1'b0;
    @(negedge clk);
    bus.loadN = 1'b0;
    check("ready_cleared_by_load", 32'(bus.ready), 32'd0);
  endtask

  // Edge count (from the loadN=0 edge, inclusive) until ready rises; 0 on timeout.
  task automatic run_op(input vec_t v, output int edges);
    start_op(v.a, v.b, v.pm, v.ci);
    edges = 0;
    for (int k = 1; k <= 40; k++) begin
      bus.loadA = (v.stall > 0) && (k < 3 + v.stall);
      @(posedge clk); #1;
      if (bus.ready) begin
        edges = k;
        break;
      end
      @(negedge clk);
    end
    bus.loadA = 1'b0;
  endtask

  initial begin
    int edges;
    //           a             b             pm    ci    st  sum           cout
    vecs[0]  = '{32'h01580000, 32'h00C00000, 1'b0, 1'b0, 0, 32'h411C0000, 1'b1}; //  6.75+3
    vecs[1]  = '{32'h01580000, 32'h80C00000, 1'b0, 1'b0, 1, 32'h40700000, 1'b0}; //  6.75+-3
    vecs[2]  = '{32'h81580000, 32'h00C00000, 1'b0, 1'b0, 0, 32'hC0700000, 1'b0}; // -6.75+3
    vecs[3]  = '{32'h81580000, 32'h80C00000, 1'b0, 1'b0, 0, 32'hC11C0000, 1'b1}; // -6.75+-3
    vecs[4]  = '{32'h01580000, 32'h00C00000, 1'b1, 1'b0, 0, 32'h40700000, 1'b0}; //  6.75-3
    vecs[5]  = '{32'h01580000, 32'h80C00000, 1'b1, 1'b0, 2, 32'h411C0000, 1'b1}; //  6.75--3
    vecs[6]  = '{32'h81580000, 32'h00C00000, 1'b1, 1'b0, 0, 32'hC11C0000, 1'b1}; // -6.75-3
    vecs[7]  = '{32'h81580000, 32'h80C00000, 1'b1, 1'b0, 0, 32'hC0700000, 1'b0}; // -6.75--3
    vecs[8]  = '{32'h01580000, 32'h01580000, 1'b1, 1'b0, 0, 32'h00000000, 1'b0}; //  A-A
    vecs[9]  = '{32'h0F000000, 32'h00C00000, 1'b0, 1'b0, 0, 32'h4E800000, 1'b0}; //  2^30+3
    vecs[10] = '{32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 0, 32'h7F800000, 1'b1}; //  overflow
    vecs[11] = '{32'h41400000, 32'h41000000, 1'b1, 1'b0, 0, 32'h00000000, 1'b0}; //  underflow
    vecs[12] = '{32'h00400000, 32'h00400000, 1'b0, 1'b1, 0, 32'h40400000, 1'b1}; //  1.5+1.5+cin
    vecs[13] = '{32'h01580000, 32'h80C00000, 1'b0, 1'b1, 0, 32'h40700000, 1'b0}; //  cin ignored
    vecs[14] = '{32'h7FC00000, 32'h00400000, 1'b0, 1'b0, 0, 32'h40100000, 1'b1}; //  0.75+1.5
    vecs[15] = '{32'h00C00000, 32'h01580000, 1'b1, 1'b0, 0, 32'hC0700000, 1'b0}; //  3-6.75
    vecs[16] = '{32'h01580000, 32'h00000000, 1'b0, 1'b0, 0, 32'h40D80000, 1'b0}; //  6.75+0

    rst = 1'b1;
    bus.en = 1'b1; bus.loadN = 1'b0; bus.loadA = 1'b0;
    bus.PlusOrMinus = 1'b0; bus.cin = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", bus.sumFinal, 32'd0);
    check("reset_cout", 32'(bus.cout), 32'd0);
    check("reset_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i], edges);
      check($sformatf("v%0d_latency", i), 32'(edges), 32'(4 + vecs[i].stall));
      check($sformatf("v%0d_sum", i), bus.sumFinal, vecs[i].exp_sum);
      check($sformatf("v%0d_cout", i), 32'(bus.cout), 32'(vecs[i].exp_cout));
    end

    // loadA in DONE: back to ADD stall, recompute after loadA falls.
    run_op(vecs[0], edges);
    @(negedge clk); bus.loadA = 1'b1;
    @(posedge clk); #1;
    check("done_loada_ready0", 32'(bus.ready), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    check("done_stall_ready0", 32'(bus.ready), 32'd0);
    @(negedge clk); bus.loadA = 1'b0;
    @(posedge clk); #1;
    check("done_norm_ready0", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    check("done_recompute_ready", 32'(bus.ready), 32'd1);
    check("done_recompute_sum", bus.sumFinal, 32'h411C0000);

    // en=0 in DONE holds everything, even with loadN high.
    @(negedge clk); bus.en = 1'b0; bus.loadN = 1'b1;
    @(posedge clk); #1;
    check("en0_done_ready", 32'(bus.ready), 32'd1);
    @(negedge clk); bus.loadN = 1'b0; bus.en = 1'b1;

    // en=0 during ADD freezes, then resumes.
    start_op(32'h01580000, 32'h00C00000, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); bus.en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("en0_add_ready", 32'(bus.ready), 32'd0);
    check("en0_add_sum", bus.sumFinal, 32'h411C0000);
    check("en0_add_cout", 32'(bus.cout), 32'd1);
    @(negedge clk); bus.en = 1'b1;
    @(posedge clk); #1;
    check("en1_norm_ready0", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    check("en1_done_ready", 32'(bus.ready), 32'd1);
    check("en1_done_sum", bus.sumFinal, 32'h40700000);

    // Reset during ALIGN.
    run_op(vecs[0], edges);
    start_op(32'h01580000, 32'h80C00000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_align_sum", bus.sumFinal, 32'd0);
    check("rst_align_cout", 32'(bus.cout), 32'd0);
    check("rst_align_ready", 32'(bus.ready), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset during ADD stall.
    run_op(vecs[3], edges);
    start_op(32'h01580000, 32'h00C00000, 1'b0, 1'b0);
    bus.loadA = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_add_sum", bus.sumFinal, 32'd0);
    check("rst_add_cout", 32'(bus.cout), 32'd0);
    check("rst_add_ready", 32'(bus.ready), 32'd0);
    @(negedge clk); rst = 1'b0; bus.loadA = 1'b0;

    // Recovery after reset.
    run_op(vecs[2], edges);
    check("post_rst_latency", 32'(edges), 32'd4);
    check("post_rst_sum", bus.sumFinal, 32'hC0700000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
